// File: rtl/mux16_serializer_if.sv
// ---------------------------------------------------------------------------
// mux16_serializer_if
//   Bus bundle between the word source, the mux16_serializer and the
//   downstream bit consumer.
//
//   Load side : load_valid / load_ready / load_data  (word handshake)
//   Mux side  : data_q / sel                         (drives mux_16x1)
//   Bit side  : ser_out / ser_valid / ser_ready / last (bit handshake)
//   Status    : busy
//
//   The slave modport is the serializer itself. The master modport is the
//   surrounding environment, which supplies words and consumes bits.
// ---------------------------------------------------------------------------
interface mux16_serializer_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] sel;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             last;
    logic             busy;

    modport slave (
        input  load_valid,
        input  load_data,
        input  ser_ready,
        output load_ready,
        output data_q,
        output sel,
        output ser_out,
        output ser_valid,
        output last,
        output busy
    );

    modport master (
        output load_valid,
        output load_data,
        output ser_ready,
        input  load_ready,
        input  data_q,
        input  sel,
        input  ser_out,
        input  ser_valid,
        input  last,
        input  busy
    );
endinterface

// File: rtl/mux16_serializer.sv
// ---------------------------------------------------------------------------
// mux16_serializer
//   Upstream sequencer for the 16x1 bit-select mux. A parallel word is
//   accepted on the load handshake and held on data_q. sel then steps one
//   index per accepted bit beat, so ser_out = data_q[sel] forms a serial
//   stream with its own valid/ready handshake.
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (aborts any word in flight)
//   bus  : mux16_serializer_if.slave
//          load_valid/load_ready/load_data : word input handshake
//          data_q/sel                      : registered mux data and select
//          ser_out/ser_valid/ser_ready     : serial bit handshake
//          last                            : current beat is final bit
//          busy                            : word being shifted out
//
// Parameters
//   WIDTH     : word width, 2..16
//   SEL_W     : select width, equal to $clog2(WIDTH)
//   MSB_FIRST : 0 -> sel runs 0..WIDTH-1, 1 -> sel runs WIDTH-1..0
// ---------------------------------------------------------------------------
module mux16_serializer #(
    parameter int WIDTH     = 16,
    parameter int SEL_W     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    mux16_serializer_if.slave     bus
);

    localparam logic [SEL_W-1:0] TOP_IDX  = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] FIRST    = MSB_FIRST ? TOP_IDX : '0;
    localparam logic [SEL_W-1:0] LAST_IDX = MSB_FIRST ? '0 : TOP_IDX;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SEL_W-1:0] sel_q,   sel_d;

    logic ser_valid;
    logic last;
    logic load_ready;
    logic load_hs;
    logic beat;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= FIRST;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    // Handshake decode and next-state logic
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sel_d      = sel_q;

        ser_valid  = (state_q == SHIFT);
        last       = ser_valid && (sel_q == LAST_IDX);
        // Accept a new word either when idle or on the final beat, so that
        // back-to-back words stream without a bubble. This makes load_ready
        // combinational from ser_ready.
        load_ready = (state_q == IDLE) || (last && bus.ser_ready);
        load_hs    = bus.load_valid && load_ready;
        beat       = ser_valid && bus.ser_ready;

        unique case (state_q)
            IDLE: begin
                if (load_hs) begin
                    data_d  = bus.load_data;
                    sel_d   = FIRST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (sel_q == LAST_IDX) begin
                        sel_d = FIRST;
                        if (load_hs) begin
                            data_d = bus.load_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (MSB_FIRST) begin
                        sel_d = sel_q - SEL_W'(1);
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output drive
    always_comb begin
        bus.load_ready = load_ready;
        bus.data_q     = data_q;
        bus.sel        = sel_q;
        bus.ser_out    = data_q[sel_q];
        bus.ser_valid  = ser_valid;
        bus.last       = last;
        bus.busy       = ser_valid;
    end

endmodule
